// File: rtl/quad_encoder_pkg.sv
// Shared definitions for the quadrature encoder bank: decode-mode encodings
// and the direction rule for a single-bit transition of the filtered phases.
package quad_encoder_pkg;

  typedef enum logic [1:0] {
    MODE_X4   = 2'b00,
    MODE_X2   = 2'b01,
    MODE_X1   = 2'b10,
    MODE_HOLD = 2'b11
  } quad_mode_t;

  // Direction of a single-bit step into state cur_ab = {a,b}.
  // Forward order is 00 -> 10 -> 11 -> 01 -> 00. When A moved, the step is
  // forward if the new A differs from B; when B moved, forward if they match.
  function automatic logic step_is_up(input logic [1:0] cur_ab, input logic a_moved);
    logic differ;
    differ = cur_ab[1] ^ cur_ab[0];
    return a_moved ? differ : ~differ;
  endfunction

endpackage

// File: rtl/quad_encoder_channel.sv
// One encoder channel: 2-flop synchroniser, per-phase glitch filter,
// transition decoder and wrapping or saturating position counter.
module quad_encoder_channel
  import quad_encoder_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int FILTER_LEN = 3,
  parameter int SATURATE   = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a,
  input  logic             b,
  input  logic [1:0]       mode,
  input  logic             clear,
  output logic [WIDTH-1:0] value,
  output logic             dir,
  output logic             err
);

  logic [1:0]       sync1_reg, sync2_reg;
  logic [1:0]       filt;
  logic [1:0]       prev_reg;
  logic [1:0]       changed;
  logic             single_chg;
  logic             illegal;
  logic             step_up;
  logic             count_en;
  logic [WIDTH-1:0] value_reg, value_next;
  logic             dir_reg, err_reg;

  // Bring the asynchronous phases into the clock domain; bit 1 = A, bit 0 = B.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_reg <= 2'b00;
      sync2_reg <= 2'b00;
    end else begin
      sync1_reg <= {a, b};
      sync2_reg <= sync1_reg;
    end
  end

  genvar gi;
  generate
    if (FILTER_LEN == 0) begin : g_no_filter
      assign filt = sync2_reg;
    end else begin : g_filter
      localparam int CW = $clog2(FILTER_LEN + 1);
      for (gi = 0; gi < 2; gi++) begin : g_bit
        logic [CW-1:0] cnt_reg;
        logic          filt_reg;
        // Accept a new level once it has differed for FILTER_LEN cycles in a row.
        always_ff @(posedge clk) begin
          if (reset) begin
            cnt_reg  <= '0;
            filt_reg <= 1'b0;
          end else if (sync2_reg[gi] == filt_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == CW'(FILTER_LEN - 1)) begin
            cnt_reg  <= '0;
            filt_reg <= sync2_reg[gi];
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        assign filt[gi] = filt_reg;
      end
    end
  endgenerate

  assign changed    = filt ^ prev_reg;
  assign single_chg = ^changed;
  assign illegal    = &changed;
  assign step_up    = step_is_up(filt, changed[1]);

  // Decide whether this filtered transition counts under the current mode.
  always_comb begin
    count_en = 1'b0;
    case (mode)
      MODE_X4: count_en = single_chg;
      MODE_X2: count_en = single_chg & changed[1];
      MODE_X1: count_en = single_chg & changed[1] & filt[1];
      default: count_en = 1'b0;
    endcase
  end

  // Next position: wrap by default, or clamp at the rails when saturating.
  always_comb begin
    value_next = value_reg;
    if (step_up) begin
      if (!(SATURATE != 0 && value_reg == '1)) value_next = value_reg + 1'b1;
    end else begin
      if (!(SATURATE != 0 && value_reg == '0)) value_next = value_reg - 1'b1;
    end
  end

  // Counter, direction and sticky error; clear beats a same-cycle count.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_reg  <= 2'b00;
      value_reg <= '0;
      dir_reg   <= 1'b1;
      err_reg   <= 1'b0;
    end else begin
      prev_reg <= filt;
      if (clear) begin
        value_reg <= '0;
        dir_reg   <= 1'b1;
        err_reg   <= 1'b0;
      end else begin
        if (illegal) err_reg <= 1'b1;
        if (count_en) begin
          value_reg <= value_next;
          dir_reg   <= step_up;
        end
      end
    end
  end

  assign value = value_reg;
  assign dir   = dir_reg;
  assign err   = err_reg;

endmodule

// File: rtl/quad_encoder_bank.sv
// Bank of independent quadrature encoder channels sharing one decode mode.
module quad_encoder_bank
  import quad_encoder_pkg::*;
#(
  parameter int CHANNELS   = 4,
  parameter int WIDTH      = 16,
  parameter int FILTER_LEN = 3,
  parameter int SATURATE   = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       a,
  input  logic [CHANNELS-1:0]       b,
  input  logic [1:0]                mode,
  input  logic [CHANNELS-1:0]       clear,
  output logic [CHANNELS*WIDTH-1:0] value,
  output logic [CHANNELS-1:0]       dir,
  output logic [CHANNELS-1:0]       err
);

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
      quad_encoder_channel #(
        .WIDTH      (WIDTH),
        .FILTER_LEN (FILTER_LEN),
        .SATURATE   (SATURATE)
      ) u_chan (
        .clk   (clk),
        .reset (reset),
        .a     (a[gi]),
        .b     (b[gi]),
        .mode  (mode),
        .clear (clear[gi]),
        .value (value[gi*WIDTH +: WIDTH]),
        .dir   (dir[gi]),
        .err   (err[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_quad_encoder_bank.sv
// Randomised self-checking bench for quad_encoder_bank against a
// transaction-level model that works on Gray-code positions.
module tb_quad_encoder_bank;

  localparam int CH = 4;
  localparam int W  = 16;

  logic          clk   = 1'b0;
  logic          reset = 1'b1;
  logic [CH-1:0] a_in  = '0;
  logic [CH-1:0] b_in  = '0;
  logic [CH-1:0] clear = '0;
  logic [1:0]    mode  = 2'b00;
  logic [CH*W-1:0] value;
  logic [CH-1:0] dir, err;

  logic [0:0] a_s = '0, b_s = '0, clear_s = '0;
  logic [3:0] value_s;
  logic [0:0] dir_s, err_s;

  int vectors     = 0;
  int miscompares = 0;

  int unsigned m_val[CH];
  bit          m_dir[CH];
  bit          m_err[CH];
  logic [1:0]  m_lvl[CH];

  always #5 clk = ~clk;

  quad_encoder_bank #(.CHANNELS(CH), .WIDTH(W), .FILTER_LEN(3), .SATURATE(0)) dut (
    .clk(clk), .reset(reset), .a(a_in), .b(b_in), .mode(mode), .clear(clear),
    .value(value), .dir(dir), .err(err)
  );

  quad_encoder_bank #(.CHANNELS(1), .WIDTH(4), .FILTER_LEN(0), .SATURATE(1)) dut_sat (
    .clk(clk), .reset(reset), .a(a_s), .b(b_s), .mode(mode), .clear(clear_s),
    .value(value_s), .dir(dir_s), .err(err_s)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Position of a level along the forward cycle 00 -> 10 -> 11 -> 01.
  function automatic int gidx(input logic [1:0] ab);
    case (ab)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [1:0] lvl_of(input int i);
    case (i % 4)
      0:       return 2'b00;
      1:       return 2'b10;
      2:       return 2'b11;
      default: return 2'b01;
    endcase
  endfunction

  function automatic void model_clear(input int ch);
    m_val[ch] = 0;
    m_dir[ch] = 1'b1;
    m_err[ch] = 1'b0;
  endfunction

  function automatic void model_apply(input int ch, input logic [1:0] nxt, input logic [1:0] md);
    int d;
    bit cnt;
    d   = (gidx(nxt) - gidx(m_lvl[ch]) + 4) % 4;
    cnt = 1'b0;
    if (d == 2) begin
      m_err[ch] = 1'b1;
    end else if (d != 0) begin
      case (md)
        2'b00: cnt = 1'b1;
        2'b01: cnt = (m_lvl[ch][1] != nxt[1]);
        2'b10: cnt = (!m_lvl[ch][1] && nxt[1]);
        default: cnt = 1'b0;
      endcase
      if (cnt) begin
        if (d == 1) begin
          m_val[ch] = (m_val[ch] + 1) % (1 << W);
          m_dir[ch] = 1'b1;
        end else begin
          m_val[ch] = (m_val[ch] + (1 << W) - 1) % (1 << W);
          m_dir[ch] = 1'b0;
        end
      end
    end
    m_lvl[ch] = nxt;
  endfunction

  task automatic set_ch(input int ch, input logic [1:0] ab);
    a_in[ch] = ab[1];
    b_in[ch] = ab[0];
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_ch(input int ch, input string stage);
    check_eq($sformatf("%s.value%0d", stage, ch), 32'(value[ch*W +: W]), m_val[ch]);
    check_eq($sformatf("%s.dir%0d", stage, ch), 32'(dir[ch]), 32'(m_dir[ch]));
    check_eq($sformatf("%s.err%0d", stage, ch), 32'(err[ch]), 32'(m_err[ch]));
  endtask

  task automatic check_all(input string stage);
    for (int ch = 0; ch < CH; ch++) check_ch(ch, stage);
  endtask

  initial begin
    logic [1:0]    nxt;
    logic [1:0]    sl;
    int            sv;
    int            r;
    logic [CH-1:0] mask;

    for (int ch = 0; ch < CH; ch++) begin
      model_clear(ch);
      m_lvl[ch] = 2'b00;
    end

    // Reset state
    reset = 1'b1;
    wait_cycles(3);
    check_all("reset");
    check_eq("reset.sat_value", 32'(value_s), 0);
    check_eq("reset.sat_dir", 32'(dir_s), 1);
    check_eq("reset.sat_err", 32'(err_s), 0);
    reset = 1'b0;
    wait_cycles(2);

    // x4 forward cycle on ch0 with latency probing
    mode = 2'b00;
    for (int s = 1; s <= 4; s++) begin
      nxt = lvl_of(s);
      set_ch(0, nxt);
      wait_cycles(5);
      check_eq($sformatf("latency_early.step%0d", s), 32'(value[W-1:0]), m_val[0]);
      wait_cycles(1);
      model_apply(0, nxt, mode);
      check_ch(0, $sformatf("x4_fwd.step%0d", s));
      wait_cycles(4);
    end
    check_all("x4_fwd_end");

    // x1, two reverse cycles on ch1
    mode = 2'b10;
    for (int s = 1; s <= 8; s++) begin
      nxt = lvl_of(4 * 4 - s);
      set_ch(1, nxt);
      wait_cycles(10);
      model_apply(1, nxt, mode);
    end
    check_all("x1_rev");

    // Saturating 4-bit instance, filter bypassed
    mode = 2'b00;
    sl = 2'b00;
    sv = 0;
    for (int s = 0; s < 20; s++) begin
      sl = lvl_of(gidx(sl) + 1);
      a_s = sl[1];
      b_s = sl[0];
      wait_cycles(5);
      sv = (sv < 15) ? sv + 1 : 15;
      check_eq($sformatf("sat_up.step%0d", s), 32'(value_s), sv);
    end
    check_eq("sat_up.dir", 32'(dir_s), 1);
    for (int s = 0; s < 20; s++) begin
      sl = lvl_of(gidx(sl) + 3);
      a_s = sl[1];
      b_s = sl[0];
      wait_cycles(5);
      sv = (sv > 0) ? sv - 1 : 0;
      check_eq($sformatf("sat_dn.step%0d", s), 32'(value_s), sv);
    end
    check_eq("sat_dn.dir", 32'(dir_s), 0);
    check_eq("sat_dn.err", 32'(err_s), 0);

    // Two-cycle glitch on ch2 A, then illegal double toggle, then clear
    a_in[2] = 1'b1;
    wait_cycles(2);
    a_in[2] = 1'b0;
    wait_cycles(8);
    check_all("glitch");
    set_ch(2, 2'b11);
    wait_cycles(8);
    model_apply(2, 2'b11, mode);
    check_all("double_toggle");
    clear[2] = 1'b1;
    wait_cycles(1);
    clear[2] = 1'b0;
    model_clear(2);
    check_all("clear_err");

    // Clear coinciding with the edge that would count on ch3
    set_ch(3, 2'b10);
    wait_cycles(5);
    clear[3] = 1'b1;
    wait_cycles(1);
    clear[3] = 1'b0;
    model_apply(3, 2'b10, mode);
    model_clear(3);
    check_all("clear_vs_count");
    wait_cycles(4);
    check_all("clear_vs_count_after");

    // Reset in the middle of a step on ch0
    set_ch(0, 2'b11);
    wait_cycles(3);
    reset = 1'b1;
    wait_cycles(1);
    for (int ch = 0; ch < CH; ch++) begin
      model_clear(ch);
      m_lvl[ch] = 2'b00;
    end
    check_all("mid_reset");
    reset = 1'b0;
    // Levels still held high must now be seen as moves away from 00
    wait_cycles(8);
    for (int ch = 0; ch < CH; ch++) model_apply(ch, {a_in[ch], b_in[ch]}, mode);
    check_all("post_reset");
    clear = '1;
    wait_cycles(1);
    clear = '0;
    for (int ch = 0; ch < CH; ch++) model_clear(ch);
    check_all("post_reset_clear");

    // Independent random traffic on all channels, random mode per period
    for (int p = 0; p < 60; p++) begin
      mode = 2'($urandom_range(0, 3));
      for (int ch = 0; ch < CH; ch++) begin
        r = int'($urandom_range(0, 15));
        if (r <= 5)       nxt = m_lvl[ch];
        else if (r <= 10) nxt = lvl_of(gidx(m_lvl[ch]) + 1);
        else if (r <= 14) nxt = lvl_of(gidx(m_lvl[ch]) + 3);
        else              nxt = ~m_lvl[ch];
        set_ch(ch, nxt);
      end
      wait_cycles(8);
      for (int ch = 0; ch < CH; ch++) model_apply(ch, {a_in[ch], b_in[ch]}, mode);
      check_all($sformatf("rand%0d", p));
      if (p % 10 == 9) begin
        mask  = CH'($urandom_range(1, 15));
        clear = mask;
        wait_cycles(1);
        clear = '0;
        for (int ch = 0; ch < CH; ch++) if (mask[ch]) model_clear(ch);
        check_all($sformatf("rand_clear%0d", p));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
